ground_scroller: RTL
====================

Name: ground_scroller

Overview:
- Parametrised successor to the single-band ground renderer.
- Holds a ROWS x PAT_W bit pattern and scrolls it horizontally once per frame while the game runs.
- Emits one registered pixel bit per VGA scan position.
- Additions over the previous generation:
  - configurable geometry;
  - runtime-writable pattern;
  - automatic speed ramp;
  - a frozen state that keeps the ground visible after game over;
  - explicit restart.

Parameters:
- PAT_W, 160, pattern period in pixels; 2..1023; must exceed SPEED_MAX.
- ROWS, 8, band height in scan lines; 1..64.
- TOP_ROW, 400, first scan line of band; TOP_ROW+ROWS <= 512.
- SPEED_W, 4, width of speed output.
- SPEED_INIT, 1, speed after reset/restart, px/frame.
- SPEED_MAX, 8, speed ceiling; < 2^SPEED_W.
- SPEED_STEP, 600, frames per +1 speed increment; 0 disables the ramp.

Ports:
- clk  in  1  pixel-domain clock (clkdiv[0] at top level).
- N_rst  in  1  asynchronous active-low reset.
- row_addr  in  9  current scan row.
- col_addr  in  10  current scan column (0..1023 legal).
- fresh  in  1  frame strobe, asynchronous to clk; a falling edge marks a frame.
- game_status  in  1  1 = game running.
- restart  in  1  single-cycle pulse: return to IDLE.
- wr_en  in  1  pattern bit write enable.
- wr_row  in  clog2(ROWS) (min 1)  row of bit to write.
- wr_col  in  clog2(PAT_W)  column of bit to write.
- wr_bit  in  1  value to write.
- px  out  1  ground pixel, registered.
- in_band  out  1  registered; 1 when the px sample came from inside the band.
- ground_position  out  clog2(PAT_W)  current scroll offset.
- speed  out  SPEED_W  current scroll speed.

Behaviour:
- Reset (asynchronous, N_rst=0):
  - px=0, in_band=0, ground_position=0, speed=SPEED_INIT, frame counter=0, state=IDLE.
  - fresh synchronisers are cleared to 0.
  - Pattern: row 0 all ones, all other rows zero.
- fresh is synchronised by 2 flops plus a history flop.
  - tick = 1-cycle pulse on synchronised 1->0.
  - tick latency is 3 clk cycles from the fresh edge.
- States:
  - IDLE: position and speed held. Goes to RUN when game_status=1 and restart=0.
  - RUN: on each tick, position and ramp advance (see below). Goes to FROZEN when game_status=0.
  - FROZEN: position and speed held; px still drawn. Leaves only on restart.
- restart=1 in any state has priority over everything except reset:
  - next state IDLE, position 0, speed SPEED_INIT, frame counter 0;
  - any tick in that same cycle is discarded.
- Position update (RUN, on tick):
  - s = ground_position + speed.
  - new = s-PAT_W if s >= PAT_W, else s.
  - Never leaves 0..PAT_W-1.
- Speed ramp (RUN, on tick, SPEED_STEP != 0):
  - frame counter increments.
  - When the counter equals SPEED_STEP-1: counter returns to 0 and speed increments unless it equals SPEED_MAX.
  - The new speed applies from the next tick; the position update in the same cycle uses the old speed.
- Pixel path (all states, 1-cycle latency):
  - band = (TOP_ROW <= row_addr < TOP_ROW+ROWS).
  - If band: x = (col_addr mod PAT_W) + ground_position, wrapped once by -PAT_W; px <= pattern[row_addr-TOP_ROW][x].
  - Otherwise px <= 0.
  - in_band <= band.
- Pattern write:
  - wr_en=1 writes wr_bit at [wr_row][wr_col] at the clk edge; this is allowed in any state.
  - Writes to out-of-range row or column are ignored.
  - A read of the same bit in the same cycle returns the old value.
  - The pattern is not altered by restart.
- Position and speed change only on clk edges, never on fresh directly.

Test Plan:
- Reset, row_addr=400, col_addr=5 -> px=1, in_band=1 one cycle later. row_addr=401 -> px=0. row_addr=399 or 408 -> px=0, in_band=0.
- game_status=1, 3 fresh falling edges at speed 1 -> ground_position=3, each change 3 clk after its edge. Rising edges of fresh cause no change.
- Set position to 158 at speed 3 -> after 1 tick, ground_position=1 (wrap). col_addr=639 with position 100 -> reads column (639 mod 160 + 100) - 160 = 99.
- SPEED_STEP=4, SPEED_MAX=3: 12 ticks in RUN -> speed 1→2 after the 4th tick, →3 after the 8th tick, stays 3 after the 12th. The position sequence confirms each new speed takes effect on the following tick.
- Drop game_status mid-run -> FROZEN; ticks leave position and speed unchanged; px still follows the pattern. Raise game_status -> stays FROZEN. Pulse restart coincident with a tick -> IDLE, position 0, speed 1, no advance.
- Write wr_row=3, wr_col=10, wr_bit=1 while reading the same pixel -> old value 0 that cycle, then 1. Assert N_rst mid-run -> all outputs return to reset values immediately and the pattern returns to default.

Source files
------------

// File: rtl/ground_scroller.sv
// ground_scroller
//
// Scrolling ground band for a VGA-style renderer. A ROWS x PAT_W bit pattern
// is shifted horizontally by `speed` pixels on every frame while the game is
// running. The speed can ramp up automatically. After game over the ground
// stays visible but stops moving. A restart pulse brings the scroller back to
// its idle start-up position.
//
// Ports
//   clk             pixel-domain clock
//   N_rst           asynchronous active-low reset
//   row_addr        current scan row (9 bits)
//   col_addr        current scan column (10 bits)
//   fresh           frame strobe, asynchronous; a falling edge marks a frame
//   game_status     1 = game running
//   restart         single-cycle pulse, returns to IDLE
//   wr_en/wr_row/wr_col/wr_bit  pattern bit write port
//   px              registered ground pixel
//   in_band         registered, 1 when px was sampled inside the band
//   ground_position current scroll offset (0..PAT_W-1)
//   speed           current scroll speed, px/frame
module ground_scroller #(
  parameter int PAT_W      = 160,
  parameter int ROWS       = 8,
  parameter int TOP_ROW    = 400,
  parameter int SPEED_W    = 4,
  parameter int SPEED_INIT = 1,
  parameter int SPEED_MAX  = 8,
  parameter int SPEED_STEP = 600,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int PW        = $clog2(PAT_W)
) (
  input  logic               clk,
  input  logic               N_rst,
  input  logic [8:0]         row_addr,
  input  logic [9:0]         col_addr,
  input  logic               fresh,
  input  logic               game_status,
  input  logic               restart,
  input  logic               wr_en,
  input  logic [RW-1:0]      wr_row,
  input  logic [PW-1:0]      wr_col,
  input  logic               wr_bit,
  output logic               px,
  output logic               in_band,
  output logic [PW-1:0]      ground_position,
  output logic [SPEED_W-1:0] speed
);

  localparam int CNT_W     = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
  localparam int STEP_LAST = (SPEED_STEP == 0) ? 0 : SPEED_STEP - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FROZEN} state_t;

  state_t             state_q, state_d;
  logic               fresh_s1_q, fresh_s2_q, fresh_h_q;
  logic               tick;
  logic [PW-1:0]      pos_q, pos_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAT_W-1:0]   pat_q [ROWS];
  logic [PAT_W-1:0]   pat_d [ROWS];
  logic               px_q, px_d, in_band_q, in_band_d;

  logic               band;
  logic [RW-1:0]      row_idx;
  logic [PW-1:0]      col_mod;
  logic [PW-1:0]      x_idx;
  logic               wr_ok;

  // Modular add of two values each below PAT_W; a single subtraction suffices.
  function automatic logic [PW-1:0] wrap_add(input logic [PW:0] a, input logic [PW:0] b);
    logic [PW:0] s;
    s = a + b;
    if (s >= (PW+1)'(PAT_W)) s = s - (PW+1)'(PAT_W);
    return s[PW-1:0];
  endfunction

  // Speed increment that saturates at the ceiling.
  function automatic logic [SPEED_W-1:0] speed_bump(input logic [SPEED_W-1:0] s);
    return (s == SPEED_W'(SPEED_MAX)) ? s : s + 1'b1;
  endfunction

  // Frame tick: falling edge of the synchronised strobe.
  assign tick = fresh_h_q & ~fresh_s2_q;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    if (restart) begin
      // Restart wins over any tick arriving in the same cycle.
      state_d = ST_IDLE;
      pos_d   = '0;
      speed_d = SPEED_W'(SPEED_INIT);
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (game_status) state_d = ST_RUN;
        ST_RUN: begin
          if (!game_status) state_d = ST_FROZEN;
          if (tick) begin
            // Position uses the pre-ramp speed; a bumped speed applies next tick.
            pos_d = wrap_add({1'b0, pos_q}, (PW+1)'(speed_q));
            if (SPEED_STEP != 0) begin
              if (cnt_q == CNT_W'(STEP_LAST)) begin
                cnt_d   = '0;
                speed_d = speed_bump(speed_q);
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
        end
        ST_FROZEN: state_d = ST_FROZEN;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    band    = ({1'b0, row_addr} >= 10'(TOP_ROW)) && ({1'b0, row_addr} < 10'(TOP_ROW + ROWS));
    row_idx = band ? RW'(row_addr - 9'(TOP_ROW)) : '0;
    col_mod = PW'(col_addr % 10'(PAT_W));
    x_idx   = wrap_add({1'b0, col_mod}, {1'b0, pos_q});
    // Reads the registered pattern, so a same-cycle write is seen one cycle later.
    px_d      = band ? pat_q[row_idx][x_idx] : 1'b0;
    in_band_d = band;
  end

  always_comb begin
    wr_ok = wr_en && ({1'b0, wr_row} < (RW+1)'(ROWS)) && ({1'b0, wr_col} < (PW+1)'(PAT_W));
    for (int r = 0; r < ROWS; r++) pat_d[r] = pat_q[r];
    if (wr_ok) pat_d[wr_row][wr_col] = wr_bit;
  end

  // Stage boundary: every registered state of the scroller.
  always_ff @(posedge clk or negedge N_rst) begin
    if (!N_rst) begin
      state_q    <= ST_IDLE;
      fresh_s1_q <= 1'b0;
      fresh_s2_q <= 1'b0;
      fresh_h_q  <= 1'b0;
      pos_q      <= '0;
      speed_q    <= SPEED_W'(SPEED_INIT);
      cnt_q      <= '0;
      px_q       <= 1'b0;
      in_band_q  <= 1'b0;
      for (int r = 0; r < ROWS; r++) pat_q[r] <= (r == 0) ? '1 : '0;
    end else begin
      state_q    <= state_d;
      fresh_s1_q <= fresh;
      fresh_s2_q <= fresh_s1_q;
      fresh_h_q  <= fresh_s2_q;
      pos_q      <= pos_d;
      speed_q    <= speed_d;
      cnt_q      <= cnt_d;
      px_q       <= px_d;
      in_band_q  <= in_band_d;
      for (int r = 0; r < ROWS; r++) pat_q[r] <= pat_d[r];
    end
  end

  assign px              = px_q;
  assign in_band         = in_band_q;
  assign ground_position = pos_q;
  assign speed           = speed_q;

endmodule
